sreg_reader: RTL and testbench
==============================

SREG_READER -- requirements
Module: sreg_reader

Interface
REQ-001 Parameter PIXEL_W, default 42, pixel word width; SHALL be even.
REQ-002 Parameter N_PIXELS, default 16, pixels read per frame; legal range 1..65535.
REQ-003 Port sclk  input  1  shift clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  single-cycle frame request.
REQ-006 Port load  output  1  parallel-load strobe to the pixel shift chain.
REQ-007 Port shift  output  1  shift-enable strobe to the pixel shift chain.
REQ-008 Port sdata_in  input  2  serial data from the chain.
- Lane 1 carries bits [41:21], MSB first.
- Lane 0 carries bits [20:0], MSB first.
REQ-009 Port pixel_out  output  PIXEL_W  assembled pixel word.
REQ-010 Port pixel_valid  output  1  pixel_out valid.
REQ-011 Port pixel_ready  input  1  downstream accept.
REQ-012 Port pixel_last  output  1  marks the final pixel of a frame; qualified by pixel_valid.
REQ-013 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM SHALL have states IDLE, LOAD, SHIFT, OUT.
REQ-015 IDLE: start=1 -> LOAD; clear pixel counter.
- start in any other state SHALL be ignored.
REQ-016 LOAD: load=1 for exactly one cycle, shift=0; next state SHIFT with bit counter 0.
REQ-017 SHIFT: each cycle sample sdata_in[1] into word bit (41-cnt) and sdata_in[0] into bit (20-cnt).
- shift=1 for cnt 0..19; shift=0 at cnt 20.
- After cnt 20 -> OUT.
- Exactly 21 samples and 20 shift pulses per pixel.
REQ-018 load and shift SHALL never be high in the same cycle.
REQ-019 OUT: pixel_valid=1 and pixel_out held stable until pixel_valid && pixel_ready.
- load and shift stay 0 while waiting (chain stalled).
REQ-020 On the OUT handshake: if pixel counter < N_PIXELS-1, increment it and go to LOAD; otherwise go to IDLE.
REQ-021 pixel_last=1 in OUT when the pixel counter equals N_PIXELS-1.
- N_PIXELS=1: every pixel is last.
REQ-022 Latency with pixel_ready held high:
- start sampled at edge 0; load high in cycle 1; samples in cycles 2..22; pixel_valid in cycle 23.
- Per-pixel period 23 cycles.
REQ-023 pixel_out SHALL change only on entry to OUT.

Reset
REQ-024 rst=1 at a clock edge SHALL take effect at that edge and force:
- state IDLE, counters 0, pixel_out 0;
- load, shift, pixel_valid, pixel_last, busy all 0.
REQ-025 rst mid-frame SHALL abort the frame; no partial pixel is emitted; next start begins a fresh frame.

Configuration
REQ-026 Macro SREG_READER_FRAME_CNT_EN defined: add output frame_id[15:0].
- frame_id resets to 0 and increments on the final pixel handshake of each frame, wrapping 65535 -> 0.
- frame_id is valid alongside pixel_out.
REQ-027 Macro not defined: no frame_id port and no counter logic.

Structure
REQ-028 Package sreg_pkg SHALL hold:
- PIXEL_W default 42;
- LANE_W = PIXEL_W/2;
- state enum sreg_rd_state_t {IDLE, LOAD, SHIFT, OUT}.
REQ-029 Sub-module sreg_lane_deser: one LANE_W-bit MSB-first deserializer per lane, instantiated twice, enable from the FSM.

Verification
REQ-030 Single pixel: chain model loaded with 42'h2AA_AAAA_AAAA, pixel_ready=1 -> pixel_out=42'h2AA_AAAA_AAAA in cycle 23, pixel_last=1 (N_PIXELS=1).
REQ-031 Frame of 4 pixels 42'h1, 42'h3FF_FFFF_FFFF, 42'h200_0000_0000, 42'h000_0010_0000 -> four words in order, pixel_last only on the 4th, 80 shift pulses and 4 load pulses total.
REQ-032 Backpressure: pixel_ready=0 for 10 cycles in OUT -> pixel_out stable, load=shift=0 throughout, handshake on the 11th cycle, next load the following cycle.
REQ-033 Reset at SHIFT cnt 10 -> next cycle all outputs 0, busy=0; a new start yields a correct full frame.
REQ-034 start pulses during busy -> ignored; exactly N_PIXELS words per frame.
REQ-035 SREG_READER_FRAME_CNT_EN: 3 frames -> frame_id reads 0, 1, 2; after preloading 65535, the next frame reads 0.

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared types and defaults for the pixel shift-chain reader.
package sreg_pkg;

  localparam int unsigned PIXEL_W   = 42;
  localparam int unsigned LANE_W    = PIXEL_W / 2;
  localparam int unsigned PIX_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } sreg_rd_state_t;

endpackage

// File: rtl/sreg_lane_deser.sv
// MSB-first serial-to-parallel converter for one lane of the pixel chain.
// o_word_c includes the bit on i_sdata, so the word is complete on the final sample.
module sreg_lane_deser #(
  parameter int unsigned W = 21
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_sdata,
  output logic [W-1:0] o_word_c
);

  logic [W-2:0] r_sr;

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= o_word_c[W-2:0];
    end
  end

  assign o_word_c = {r_sr, i_sdata};

endmodule

// File: rtl/sreg_reader.sv
// Frame reader for a two-lane pixel shift chain: load, shift out, hand pixels downstream.
// Optional frame counter output frame_id enabled by defining SREG_READER_FRAME_CNT_EN.
module sreg_reader #(
  parameter int unsigned PIXEL_W  = sreg_pkg::PIXEL_W,
  parameter int unsigned N_PIXELS = 16
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               start,
  output logic               load,
  output logic               shift,
  input  logic [1:0]         sdata_in,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               pixel_last,
`ifdef SREG_READER_FRAME_CNT_EN
  output logic [15:0]        frame_id,
`endif
  output logic               busy
);

  import sreg_pkg::*;

  localparam int unsigned DESER_W   = PIXEL_W / 2;
  localparam int unsigned BIT_CNT_W = (DESER_W > 1) ? $clog2(DESER_W) : 1;
  localparam int unsigned LAST_BIT  = DESER_W - 1;
  localparam int unsigned LAST_PIX  = N_PIXELS - 1;

  sreg_rd_state_t r_state, w_state_nxt;

  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [PIX_CNT_W-1:0] r_pix_cnt, w_pix_cnt_nxt;
  logic [PIXEL_W-1:0]   r_pixel;
  logic [DESER_W-1:0]   w_word_hi, w_word_lo;

  logic r_load, r_shift, r_valid, r_last, r_busy;
  logic w_load_nxt, w_shift_nxt, w_valid_nxt, w_last_nxt, w_busy_nxt;
  logic w_hs, w_samp, w_pix_cap, w_more_pix;

  assign w_hs       = r_valid & pixel_ready;
  assign w_samp     = (r_state == SHIFT);
  assign w_more_pix = (r_pix_cnt < PIX_CNT_W'(LAST_PIX));

  // Lane 1 feeds the upper half of the pixel word, lane 0 the lower half.
  sreg_lane_deser #(.W(DESER_W)) u_deser_hi (
    .i_sclk   (sclk),
    .i_rst    (rst),
    .i_en     (w_samp),
    .i_sdata  (sdata_in[1]),
    .o_word_c (w_word_hi)
  );

  sreg_lane_deser #(.W(DESER_W)) u_deser_lo (
    .i_sclk   (sclk),
    .i_rst    (rst),
    .i_en     (w_samp),
    .i_sdata  (sdata_in[0]),
    .o_word_c (w_word_lo)
  );

  // Next state plus next values of the registered strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_pix_cnt_nxt = r_pix_cnt;
    w_pix_cap     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = LOAD;
          w_pix_cnt_nxt = '0;
        end
      end
      LOAD: begin
        w_state_nxt   = SHIFT;
        w_bit_cnt_nxt = '0;
      end
      SHIFT: begin
        if (r_bit_cnt == BIT_CNT_W'(LAST_BIT)) begin
          w_state_nxt = OUT;
          w_pix_cap   = 1'b1;
        end else begin
          w_bit_cnt_nxt = BIT_CNT_W'(r_bit_cnt + 1'b1);
        end
      end
      OUT: begin
        if (w_hs) begin
          if (w_more_pix) begin
            w_pix_cnt_nxt = PIX_CNT_W'(r_pix_cnt + 1'b1);
            w_state_nxt   = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // The chain holds its last bit in place: no shift after the final sample.
    w_load_nxt  = (w_state_nxt == LOAD);
    w_shift_nxt = (w_state_nxt == SHIFT) && (w_bit_cnt_nxt != BIT_CNT_W'(LAST_BIT));
    w_valid_nxt = (w_state_nxt == OUT);
    w_last_nxt  = (w_state_nxt == OUT) && (w_pix_cnt_nxt == PIX_CNT_W'(LAST_PIX));
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_pix_cnt <= '0;
      r_load    <= 1'b0;
      r_shift   <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_pixel   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_pix_cnt <= w_pix_cnt_nxt;
      r_load    <= w_load_nxt;
      r_shift   <= w_shift_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
      if (w_pix_cap) begin
        r_pixel <= PIXEL_W'({w_word_hi, w_word_lo});
      end
    end
  end

  assign load        = r_load;
  assign shift       = r_shift;
  assign pixel_out   = r_pixel;
  assign pixel_valid = r_valid;
  assign pixel_last  = r_last;
  assign busy        = r_busy;

`ifdef SREG_READER_FRAME_CNT_EN
  logic [15:0] r_frame_id;
  logic        w_frame_done;

  assign w_frame_done = (r_state == OUT) && w_hs && !w_more_pix;

  // Advances after the final pixel handshake so the id stays tied to its frame.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_frame_id <= '0;
    end else if (w_frame_done) begin
      r_frame_id <= 16'(r_frame_id + 1'b1);
    end
  end

  assign frame_id = r_frame_id;
`endif

endmodule

// File: tb/tb_sreg_reader.sv
// Bench for sreg_reader: shift-chain model, pixel scoreboard, directed and random frames.
`timescale 1ns/1ps
module tb_sreg_reader;

  localparam int unsigned PW = 42;
  localparam int unsigned HW = PW / 2;
  localparam int          NP = 4;

  typedef struct {
    logic [PW-1:0] word;
    logic          last;
    logic [15:0]   fid;
  } pix_rec_t;

  typedef struct {
    logic [PW-1:0] pix;
    logic [PW-1:0] exp_word;
    logic          exp_last;
  } vec_t;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic          rst, start, pixel_ready, start1, ready1;
  logic [1:0]    sdata_in, sdata1;
  logic          load, shift, pixel_valid, pixel_last, busy;
  logic          load1, shift1, valid1, last1, busy1;
  logic [PW-1:0] pixel_out, pout1;
`ifdef SREG_READER_FRAME_CNT_EN
  logic [15:0]   fid, fid1;
`endif

  sreg_reader #(.PIXEL_W(PW), .N_PIXELS(NP)) u_dut (
    .sclk        (sclk),
    .rst         (rst),
    .start       (start),
    .load        (load),
    .shift       (shift),
    .sdata_in    (sdata_in),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_last  (pixel_last),
`ifdef SREG_READER_FRAME_CNT_EN
    .frame_id    (fid),
`endif
    .busy        (busy)
  );

  sreg_reader #(.PIXEL_W(PW), .N_PIXELS(1)) u_dut1 (
    .sclk        (sclk),
    .rst         (rst),
    .start       (start1),
    .load        (load1),
    .shift       (shift1),
    .sdata_in    (sdata1),
    .pixel_out   (pout1),
    .pixel_valid (valid1),
    .pixel_ready (ready1),
    .pixel_last  (last1),
`ifdef SREG_READER_FRAME_CNT_EN
    .frame_id    (fid1),
`endif
    .busy        (busy1)
  );

  // Shift-chain models: a loaded pixel is presented one bit position per shift.
  logic [PW-1:0] src_q[$];
  logic [PW-1:0] src1_q[$];
  logic [PW-1:0] ch_word = '0, ch1_word = '0;
  int            ch_pos = 0, ch1_pos = 0;

  always @(posedge sclk) begin
    if (load) begin
      ch_word <= (src_q.size() > 0) ? src_q.pop_front() : '0;
      ch_pos  <= 0;
    end else if (shift) begin
      ch_pos <= ch_pos + 1;
    end
    if (load1) begin
      ch1_word <= (src1_q.size() > 0) ? src1_q.pop_front() : '0;
      ch1_pos  <= 0;
    end else if (shift1) begin
      ch1_pos <= ch1_pos + 1;
    end
  end

  always_comb begin
    sdata_in = 2'b00;
    sdata1   = 2'b00;
    if (ch_pos < int'(HW))  sdata_in = {ch_word[PW-1-ch_pos], ch_word[HW-1-ch_pos]};
    if (ch1_pos < int'(HW)) sdata1   = {ch1_word[PW-1-ch1_pos], ch1_word[HW-1-ch1_pos]};
  end

  // Monitor: strobe counts, protocol violations, accepted pixels.
  pix_rec_t      got_q[$];
  pix_rec_t      exp_q[$];
  int            n_load = 0, n_shift = 0, n_overlap = 0, n_stall_bad = 0, n_unstable = 0;
  logic [PW-1:0] prev_out = '0;
  logic          prev_valid = 1'b0;

  always @(negedge sclk) begin
    pix_rec_t r;
    if (load)  n_load++;
    if (shift) n_shift++;
    if (load && shift) n_overlap++;
    if (pixel_valid && (load || shift)) n_stall_bad++;
    if (!rst && (pixel_out !== prev_out) && !(pixel_valid && !prev_valid)) n_unstable++;
    prev_out   = pixel_out;
    prev_valid = pixel_valid;
    if (pixel_valid && pixel_ready) begin
      r.word = pixel_out;
      r.last = pixel_last;
`ifdef SREG_READER_FRAME_CNT_EN
      r.fid  = fid;
`else
      r.fid  = '0;
`endif
      got_q.push_back(r);
    end
  end

  int n_chk = 0, n_pass = 0, exp_fid = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic push_exp(input logic [PW-1:0] w, input int idx);
    pix_rec_t e;
    src_q.push_back(w);
    e.word = w;
    e.last = (idx == NP - 1);
    e.fid  = 16'(exp_fid);
    exp_q.push_back(e);
    if (idx == NP - 1) exp_fid++;
  endtask

  task automatic drain_check(input string tag);
    pix_rec_t g, e;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_word"}, 64'(g.word), 64'(e.word));
      chk({tag, "_last"}, 64'(g.last), 64'(e.last));
`ifdef SREG_READER_FRAME_CNT_EN
      chk({tag, "_fid"}, 64'(g.fid), 64'(e.fid));
`endif
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    src_q.delete();
    src1_q.delete();
    got_q.delete();
    exp_q.delete();
    exp_fid = 0;
  endtask

  function automatic logic [PW-1:0] rnd_pix();
    return PW'({$urandom(), $urandom()});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[NP];
    logic [23:0]   ld_v, sh_v, vl_v;
    logic [PW-1:0] w0;
    int            base_ld, base_sh, c, bp_bad;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; pixel_ready = 1'b1; ready1 = 1'b1;
    tbl[0] = '{pix: 42'h1,             exp_word: 42'h1,             exp_last: 1'b0};
    tbl[1] = '{pix: 42'h3FF_FFFF_FFFF, exp_word: 42'h3FF_FFFF_FFFF, exp_last: 1'b0};
    tbl[2] = '{pix: 42'h200_0000_0000, exp_word: 42'h200_0000_0000, exp_last: 1'b0};
    tbl[3] = '{pix: 42'h000_0010_0000, exp_word: 42'h000_0010_0000, exp_last: 1'b1};

    // Reset state
    do_reset();
    @(negedge sclk);
    chk("rst_load",  64'(load),        64'd0);
    chk("rst_shift", 64'(shift),       64'd0);
    chk("rst_valid", 64'(pixel_valid), 64'd0);
    chk("rst_last",  64'(pixel_last),  64'd0);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_pixel", 64'(pixel_out),   64'd0);
    chk("rst_busy1", 64'(busy1),       64'd0);

    // Single pixel on the N_PIXELS=1 instance, cycle-accurate latency
    tick();
    src1_q.push_back(42'h2AA_AAAA_AAAA);
    ld_v = '0; sh_v = '0; vl_v = '0;
    start1 = 1'b1;
    @(posedge sclk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge sclk);
      ld_v[k] = load1;
      sh_v[k] = shift1;
      vl_v[k] = valid1;
    end
    chk("sp_word",          64'(pout1),  64'(42'h2AA_AAAA_AAAA));
    chk("sp_last",          64'(last1),  64'd1);
    chk("sp_load_pattern",  64'(ld_v),   64'h000002);
    chk("sp_shift_pattern", 64'(sh_v),   64'h3FFFFC);
    chk("sp_valid_pattern", 64'(vl_v),   64'h800000);
    @(negedge sclk);
    chk("sp_done_busy",     64'(busy1),  64'd0);
    chk("sp_done_valid",    64'(valid1), 64'd0);
`ifdef SREG_READER_FRAME_CNT_EN
    chk("sp_fid_after",     64'(fid1),   64'd1);
`endif

    // Table-driven frame of four pixels, ready held high
    tick();
    base_ld = n_load;
    base_sh = n_shift;
    for (int i = 0; i < NP; i++) src_q.push_back(tbl[i].pix);
    pixel_ready = 1'b1;
    pulse_start();
    wait_idle("tbl_idle", 200);
    chk("tbl_count", 64'(got_q.size()), 64'(NP));
    for (int i = 0; i < NP; i++) begin
      if (got_q.size() > 0) begin
        pix_rec_t g;
        g = got_q.pop_front();
        chk($sformatf("tbl_word%0d", i), 64'(g.word), 64'(tbl[i].exp_word));
        chk($sformatf("tbl_last%0d", i), 64'(g.last), 64'(tbl[i].exp_last));
`ifdef SREG_READER_FRAME_CNT_EN
        chk($sformatf("tbl_fid%0d", i), 64'(g.fid), 64'(exp_fid));
`endif
      end
    end
    exp_fid++;
    got_q.delete();
    chk("tbl_loads",  64'(n_load - base_ld),  64'd4);
    chk("tbl_shifts", 64'(n_shift - base_sh), 64'd80);

    // Backpressure: ten stalled cycles in OUT, accept on the eleventh
    for (int i = 0; i < NP; i++) push_exp(rnd_pix(), i);
    pixel_ready = 1'b0;
    pulse_start();
    c = 0;
    while (!pixel_valid && c < 100) begin
      @(negedge sclk);
      c++;
    end
    chk("bp_valid_seen", 64'(pixel_valid), 64'd1);
    w0 = pixel_out;
    bp_bad = (load || shift) ? 1 : 0;
    for (int i = 2; i <= 10; i++) begin
      @(negedge sclk);
      if (!pixel_valid || (pixel_out !== w0) || load || shift) bp_bad++;
    end
    chk("bp_hold", 64'(bp_bad), 64'd0);
    @(posedge sclk);
    #1 pixel_ready = 1'b1;
    @(negedge sclk);
    chk("bp_c11_valid", 64'(pixel_valid), 64'd1);
    chk("bp_c11_word",  64'(pixel_out),   64'(w0));
    @(negedge sclk);
    chk("bp_next_load",  64'(load),        64'd1);
    chk("bp_next_valid", 64'(pixel_valid), 64'd0);
    wait_idle("bp_idle", 300);
    drain_check("bp");

    // Reset in SHIFT with bit count 10 (cycle 12 after start)
    for (int i = 0; i < NP; i++) src_q.push_back(rnd_pix());
    pulse_start();
    repeat (11) tick();
    chk("ra_pre_shift", 64'(shift), 64'd1);
    rst = 1'b1;
    tick();
    @(negedge sclk);
    chk("ra_load",  64'(load),        64'd0);
    chk("ra_shift", 64'(shift),       64'd0);
    chk("ra_valid", 64'(pixel_valid), 64'd0);
    chk("ra_last",  64'(pixel_last),  64'd0);
    chk("ra_busy",  64'(busy),        64'd0);
    chk("ra_pixel", 64'(pixel_out),   64'd0);
    @(posedge sclk);
    #1 rst = 1'b0;
    chk("ra_no_partial", 64'(got_q.size()), 64'd0);
    src_q.delete();
    got_q.delete();
    exp_fid = 0;
    for (int i = 0; i < NP; i++) push_exp(rnd_pix(), i);
    pulse_start();
    wait_idle("ra_idle", 200);
    drain_check("ra_fresh");

    // Start pulses while busy are ignored
    base_ld = n_load;
    for (int i = 0; i < NP; i++) push_exp(rnd_pix(), i);
    pulse_start();
    c = 0;
    while (busy && c < 300) begin
      start = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    start = 1'b0;
    chk("ign_idle", 64'(busy), 64'd0);
    repeat (30) tick();
    chk("ign_still_idle", 64'(busy), 64'd0);
    chk("ign_loads", 64'(n_load - base_ld), 64'(NP));
    drain_check("ign");

    // Random frames with random backpressure and stray starts
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NP; i++) push_exp(rnd_pix(), i);
      pulse_start();
      c = 0;
      while (busy && c < 2000) begin
        pixel_ready = ($urandom_range(0, 3) != 0);
        start       = ($urandom_range(0, 7) == 0);
        tick();
        c++;
      end
      start = 1'b0;
      pixel_ready = 1'b1;
      chk($sformatf("rnd_idle%0d", f), 64'(busy), 64'd0);
      drain_check($sformatf("rnd%0d", f));
    end

    chk("no_load_shift_overlap", 64'(n_overlap),   64'd0);
    chk("quiet_while_valid",     64'(n_stall_bad), 64'd0);
    chk("pixel_out_stable",      64'(n_unstable),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
